// File: rtl/fetch_unit.sv
// Instruction-fetch stage: single-outstanding imem handshake, static branch
// prediction, execute redirects and decode stalls; drives a NOP bubble when idle.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0033
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall_n,
  output logic [31:0] InstrF,
  output logic [31:0] PCF,
  output logic [31:0] PCplus4F,
  output logic        branch_predicted_taken,
  output logic [31:0] branch_target
);

  // Handshake: a request is accepted at the posedge where imem_req_valid and
  // imem_req_ready are both high; a response is taken when imem_resp_valid is
  // high in WAIT (or DRAIN, where it is discarded). One request in flight max.
  typedef enum logic [1:0] {REQ, WAIT, HOLD, DRAIN} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_buf_q, instr_buf_d;

  logic        handshake;
  logic [6:0]  opcode;
  logic [31:0] imm_b, imm_j;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic [31:0] pc_plus4;
  logic [31:0] next_pc;

  assign handshake = (state_q == REQ) && imem_req_ready;
  assign opcode    = instr_buf_q[6:0];
  assign imm_b     = {{19{instr_buf_q[31]}}, instr_buf_q[31], instr_buf_q[7],
                      instr_buf_q[30:25], instr_buf_q[11:8], 1'b0};
  assign imm_j     = {{11{instr_buf_q[31]}}, instr_buf_q[31], instr_buf_q[19:12],
                      instr_buf_q[20], instr_buf_q[30:21], 1'b0};
  assign pc_plus4  = pc_q + 32'd4;

  always_comb begin
    pred_taken  = 1'b0;
    pred_target = 32'h0;
    case (opcode)
      7'b1100011: begin
        pred_target = pc_q + imm_b;
        pred_taken  = instr_buf_q[31];
      end
      7'b1101111: begin
        pred_target = pc_q + imm_j;
        pred_taken  = 1'b1;
      end
      default: ;
    endcase
    next_pc = pred_taken ? pred_target : pc_plus4;
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_buf_d = instr_buf_q;
    if (redirect_valid) begin
      // A redirect squashes whatever is in flight; DRAIN absorbs the orphan response.
      pc_d = redirect_pc & 32'hFFFF_FFFC;
      case (state_q)
        REQ:     state_d = handshake ? DRAIN : REQ;
        WAIT:    state_d = imem_resp_valid ? REQ : DRAIN;
        HOLD: begin
          state_d     = REQ;
          instr_buf_d = NOP;
        end
        DRAIN:   state_d = imem_resp_valid ? REQ : DRAIN;
        default: state_d = REQ;
      endcase
    end else begin
      case (state_q)
        REQ:  if (handshake) state_d = WAIT;
        WAIT: if (imem_resp_valid) begin
          instr_buf_d = imem_resp_data;
          state_d     = HOLD;
        end
        HOLD: if (stall_n) begin
          pc_d    = next_pc;
          state_d = REQ;
        end
        DRAIN:   if (imem_resp_valid) state_d = REQ;
        default: state_d = REQ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= REQ;
      pc_q        <= RESET_PC;
      instr_buf_q <= NOP;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      instr_buf_q <= instr_buf_d;
    end
  end

  always_comb begin
    imem_req_valid         = (state_q == REQ);
    imem_addr              = pc_q & 32'hFFFF_FFFC;
    InstrF                 = NOP;
    PCF                    = 32'h0;
    PCplus4F               = 32'h0;
    branch_predicted_taken = 1'b0;
    branch_target          = 32'h0;
    if (state_q == HOLD) begin
      InstrF                 = instr_buf_q;
      PCF                    = pc_q;
      PCplus4F               = pc_plus4;
      branch_predicted_taken = pred_taken;
      branch_target          = pred_target;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a table of single-fetch vectors plus
// hand-written sequences for redirect, stall and reset corner cases.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0033;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall_n;
  logic [31:0] InstrF;
  logic [31:0] PCF;
  logic [31:0] PCplus4F;
  logic        branch_predicted_taken;
  logic [31:0] branch_target;

  int unsigned n_vec;
  int unsigned n_miss;

  typedef struct {
    logic [31:0] rpc;
    logic [31:0] instr;
    logic [31:0] exp_pc;
    logic        exp_taken;
    logic [31:0] exp_target;
    logic [31:0] exp_next;
  } vec_t;

  vec_t vecs[7];

  fetch_unit #(.RESET_PC(32'h0000_0000), .NOP(NOP)) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .imem_req_valid         (imem_req_valid),
    .imem_req_ready         (imem_req_ready),
    .imem_addr              (imem_addr),
    .imem_resp_valid        (imem_resp_valid),
    .imem_resp_data         (imem_resp_data),
    .redirect_valid         (redirect_valid),
    .redirect_pc            (redirect_pc),
    .stall_n                (stall_n),
    .InstrF                 (InstrF),
    .PCF                    (PCF),
    .PCplus4F               (PCplus4F),
    .branch_predicted_taken (branch_predicted_taken),
    .branch_target          (branch_target)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_bubble(input string tag);
    chk({tag, ".instr"},  InstrF, NOP);
    chk({tag, ".pcf"},    PCF, 32'h0);
    chk({tag, ".pc4"},    PCplus4F, 32'h0);
    chk({tag, ".taken"},  {31'h0, branch_predicted_taken}, 32'h0);
    chk({tag, ".target"}, branch_target, 32'h0);
  endtask

  // driver: point pc via redirect while REQ is not handshaking
  task automatic drive_redirect_in_req(input logic [31:0] pc);
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    tick();
    redirect_valid = 1'b0;
  endtask

  // driver: from REQ, handshake then respond next cycle -> lands in HOLD
  task automatic drive_fetch(input logic [31:0] instr);
    imem_req_ready  = 1'b1;
    tick();
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data  = instr;
    tick();
    imem_resp_valid = 1'b0;
  endtask

  initial begin
    n_vec  = 0;
    n_miss = 0;
    // rpc, instr, exp PCF, taken, target, next imem_addr
    vecs[0] = '{32'h0000_0000, 32'h0000_0013, 32'h0000_0000, 1'b0, 32'h0000_0000, 32'h0000_0004};
    vecs[1] = '{32'h0000_0102, 32'hFF9F_F06F, 32'h0000_0100, 1'b1, 32'h0000_00F8, 32'h0000_00F8};
    vecs[2] = '{32'h0000_0020, 32'h0000_0863, 32'h0000_0020, 1'b0, 32'h0000_0030, 32'h0000_0024};
    vecs[3] = '{32'h0000_0080, 32'hFE00_08E3, 32'h0000_0080, 1'b1, 32'h0000_0070, 32'h0000_0070};
    vecs[4] = '{32'h0000_0300, 32'h0000_80E7, 32'h0000_0300, 1'b0, 32'h0000_0000, 32'h0000_0304};
    vecs[5] = '{32'h0000_0004, 32'hFF9F_F06F, 32'h0000_0004, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC};
    vecs[6] = '{32'hFFFF_FFFC, 32'h0000_0013, 32'hFFFF_FFFC, 1'b0, 32'h0000_0000, 32'h0000_0000};

    rst_n           = 1'b0;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
    redirect_valid  = 1'b0;
    redirect_pc     = 32'h0;
    stall_n         = 1'b1;
    #12;
    chk_bubble("rst");
    chk("rst.req_valid", {31'h0, imem_req_valid}, 32'h1);
    chk("rst.addr", imem_addr, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();

    // first fetch straight out of reset, always-ready memory
    chk("t1.addr", imem_addr, 32'h0);
    chk("t1.req_valid", {31'h0, imem_req_valid}, 32'h1);
    drive_fetch(32'h0000_0013);
    chk("t1.instr", InstrF, 32'h0000_0013);
    chk("t1.pcf", PCF, 32'h0);
    chk("t1.pc4", PCplus4F, 32'h4);
    chk("t1.taken", {31'h0, branch_predicted_taken}, 32'h0);
    chk("t1.req_off", {31'h0, imem_req_valid}, 32'h0);
    tick();
    chk("t1.next_addr", imem_addr, 32'h4);

    // table of single fetches
    for (int i = 0; i < 7; i++) begin
      drive_redirect_in_req(vecs[i].rpc);
      chk($sformatf("v%0d.addr", i), imem_addr, vecs[i].exp_pc);
      chk($sformatf("v%0d.bubble", i), InstrF, NOP);
      drive_fetch(vecs[i].instr);
      chk($sformatf("v%0d.instr", i), InstrF, vecs[i].instr);
      chk($sformatf("v%0d.pcf", i), PCF, vecs[i].exp_pc);
      chk($sformatf("v%0d.pc4", i), PCplus4F, vecs[i].exp_pc + 32'd4);
      chk($sformatf("v%0d.taken", i), {31'h0, branch_predicted_taken}, {31'h0, vecs[i].exp_taken});
      chk($sformatf("v%0d.target", i), branch_target, vecs[i].exp_target);
      tick();
      chk($sformatf("v%0d.next", i), imem_addr, vecs[i].exp_next);
      chk($sformatf("v%0d.req", i), {31'h0, imem_req_valid}, 32'h1);
    end

    // redirect in WAIT, response two cycles later is discarded
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0203;
    tick();
    redirect_valid = 1'b0;
    chk("rw.drain_req", {31'h0, imem_req_valid}, 32'h0);
    chk_bubble("rw.drain");
    tick();
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h0000_0013;
    tick();
    imem_resp_valid = 1'b0;
    chk_bubble("rw.req");
    chk("rw.addr", imem_addr, 32'h200);
    chk("rw.req_valid", {31'h0, imem_req_valid}, 32'h1);

    // redirect in WAIT with the response in the same cycle -> straight to REQ
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready  = 1'b0;
    redirect_valid  = 1'b1;
    redirect_pc     = 32'h0000_0600;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h0000_0013;
    tick();
    redirect_valid  = 1'b0;
    imem_resp_valid = 1'b0;
    chk("rws.req_valid", {31'h0, imem_req_valid}, 32'h1);
    chk("rws.addr", imem_addr, 32'h600);
    chk("rws.instr", InstrF, NOP);

    // redirect coinciding with a handshake -> DRAIN, then REQ at new pc
    imem_req_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0700;
    tick();
    imem_req_ready = 1'b0;
    redirect_valid = 1'b0;
    chk("rh.drain_req", {31'h0, imem_req_valid}, 32'h0);
    imem_resp_valid = 1'b1;
    tick();
    imem_resp_valid = 1'b0;
    chk("rh.req_valid", {31'h0, imem_req_valid}, 32'h1);
    chk("rh.addr", imem_addr, 32'h700);
    chk("rh.instr", InstrF, NOP);

    // stall in HOLD for three cycles
    drive_redirect_in_req(32'h0000_0040);
    stall_n = 1'b0;
    drive_fetch(32'h0010_0093);
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("st%0d.instr", c), InstrF, 32'h0010_0093);
      chk($sformatf("st%0d.pcf", c), PCF, 32'h40);
      chk($sformatf("st%0d.pc4", c), PCplus4F, 32'h44);
      chk($sformatf("st%0d.req", c), {31'h0, imem_req_valid}, 32'h0);
      tick();
    end
    stall_n = 1'b1;
    tick();
    chk("st.next_addr", imem_addr, 32'h44);
    chk("st.bubble", InstrF, NOP);

    // redirect while stalled in HOLD
    stall_n = 1'b0;
    drive_fetch(32'h0000_0013);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0800;
    tick();
    redirect_valid = 1'b0;
    stall_n        = 1'b1;
    chk("rhold.addr", imem_addr, 32'h800);
    chk("rhold.req", {31'h0, imem_req_valid}, 32'h1);
    chk("rhold.instr", InstrF, NOP);

    // reset during WAIT, response lands during reset and in REQ
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_bubble("rstw");
    chk("rstw.req", {31'h0, imem_req_valid}, 32'h1);
    chk("rstw.addr", imem_addr, 32'h0);
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h0000_0013;
    tick();
    rst_n = 1'b1;
    tick();
    imem_resp_valid = 1'b0;
    chk("rstw.post_req", {31'h0, imem_req_valid}, 32'h1);
    chk("rstw.post_instr", InstrF, NOP);
    chk("rstw.post_addr", imem_addr, 32'h0);
    drive_fetch(32'h0000_0013);
    chk("rstw.fetch_pcf", PCF, 32'h0);
    chk("rstw.fetch_instr", InstrF, 32'h0000_0013);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage of the ATLAS RV32I core. It is the producer end of the fetch→decode interface.
- Keeps the fetch PC and runs a single-outstanding request/response handshake to instruction memory.
- Applies static branch prediction: backward-taken conditional branches, JAL always taken.
- Presents InstrF/PCF/PCplus4F/prediction to the decode stage and honours execute-stage redirects and decode stalls.
- Drives a NOP bubble whenever no valid instruction is available.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset.
NOP, 32'h0000_0033, bubble instruction driven on InstrF (add x0,x0,x0).

Ports:
clk  in  1  core clock
rst_n  in  1  reset; asynchronous, active-low
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request when both valid and ready are high at posedge
imem_addr  out  32  request address (word aligned)
imem_resp_valid  in  1  response data valid
imem_resp_data  in  32  instruction word
redirect_valid  in  1  execute mispredict/jalr redirect
redirect_pc  in  32  corrected PC
stall_n  in  1  0 = decode stalled, hold outputs
InstrF  out  32  instruction to decode
PCF  out  32  PC of InstrF
PCplus4F  out  32  PCF+4
branch_predicted_taken  out  1  static prediction for InstrF
branch_target  out  32  predicted target for InstrF

Behaviour:
- Registers:
  - pc_reg, reset RESET_PC.
  - instr_buf, reset NOP.
  - state, reset REQ.
- Outputs during reset and whenever state≠HOLD (bubble): InstrF=NOP, PCF=0, PCplus4F=0, branch_predicted_taken=0, branch_target=0, imem_req_valid=0 (except state REQ).
- imem_addr = {pc_reg[31:2],2'b00} at all times. imem_req_valid=1 only in REQ.
- Only one request may be outstanding.
- State REQ:
  - On handshake (valid&ready) → WAIT.
  - Otherwise stay in REQ.
  - imem_resp_valid is ignored in REQ.
- State WAIT:
  - imem_resp_valid=1 → instr_buf<=imem_resp_data, go to HOLD.
- State HOLD:
  - InstrF=instr_buf, PCF=pc_reg, PCplus4F=pc_reg+4, plus the prediction outputs below.
  - stall_n=0 → all outputs held stable, no request issued.
  - stall_n=1 → instruction consumed at this edge; pc_reg<=next_pc, go to REQ.
- State DRAIN: waits for the response of a squashed request.
  - When imem_resp_valid=1, discard the data and go to REQ.
- Prediction (combinational on instr_buf, HOLD only):
  - immB = sext({i[31],i[7],i[30:25],i[11:8],0}); immJ = sext({i[31],i[19:12],i[20],i[30:21],0}).
  - Opcode 1100011 (BRANCH): branch_target=PCF+immB; taken = i[31].
  - Opcode 1101111 (JAL): branch_target=PCF+immJ; taken=1.
  - All other opcodes, including JALR: taken=0, target=0.
  - next_pc = taken ? branch_target : PCF+4.
  - All adds are 32-bit and wrap mod 2^32.
- Redirect (priority over every other event):
  - pc_reg<={redirect_pc[31:2],2'b00}.
  - In REQ without handshake → stay in REQ.
  - In REQ with handshake in the same cycle → DRAIN.
  - In WAIT without response → DRAIN.
  - In WAIT with response in the same cycle → discard the data, go to REQ.
  - In HOLD (stalled or not) → drop instr_buf, go to REQ.
  - In DRAIN → stay in DRAIN; if the response arrives in the same cycle → REQ.
- Latency: with an always-ready memory that responds one cycle after handshake, REQ→WAIT→HOLD gives 3 cycles per instruction.
- Reset asserted mid-operation: state returns to REQ and outputs go to the bubble immediately (asynchronous). A late response is ignored because REQ ignores imem_resp_valid.

Test Plan:
1. Release reset, memory always ready, responds 0x00000013 → imem_addr=0x0 in REQ; in HOLD InstrF=0x13, PCF=0, PCplus4F=4, taken=0; next imem_addr=0x4.
2. Fetch 0xFF9FF06F (jal x0,-8) at PC 0x100 → branch_predicted_taken=1, branch_target=0xF8, next imem_addr=0xF8.
3. Fetch 0x00000863 (beq x0,x0,+16) at PC 0x20 → taken=0, branch_target=0x30, next imem_addr=0x24.
4. Redirect in WAIT:
   - Stimulus: redirect_valid=1, redirect_pc=0x203 while in WAIT; response arrives 2 cycles later.
   - Required: response discarded, InstrF stays NOP, next request imem_addr=0x200.
5. Stall in HOLD:
   - Stimulus: stall_n=0 for 3 cycles in HOLD with InstrF=0x00100093 at PC 0x40.
   - Required: outputs unchanged, imem_req_valid=0; after stall_n=1, next imem_addr=0x44.
6. Reset during WAIT:
   - Stimulus: rst_n=0 in WAIT, response arrives while in reset/REQ.
   - Required: InstrF=NOP at once, response ignored, first request after release at RESET_PC.
